// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

    // Operand-collection and issue phases of one ALU transaction.
    typedef enum logic [2:0] {
        ST_LD_OP = 3'd0,
        ST_LD_A  = 3'd1,
        ST_LD_B  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    localparam int OP_W = 4;

    // Bit positions on the bidirectional uio bus.
    localparam int UIO_STB     = 0;
    localparam int UIO_ABT     = 1;
    localparam int UIO_BUSY    = 2;
    localparam int UIO_ERR     = 3;
    localparam int UIO_FLG_LSB = 4;

    // Bits [7:2] are driven outputs, [1:0] are the strobe/abort inputs.
    localparam logic [7:0] UIO_OE = 8'hFC;

endpackage

// File: rtl/alu_op_sequencer_sync_edge.sv
// Multi-stage pin synchronizer with a registered-level output and a
// one-cycle pulse on each rising edge of the synchronized level.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchronizer and remember the last level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // pre-edge value of its neighbour; blocking would collapse the chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Collects opcode and two operands over the Tiny Tapeout pins, issues one
// ALU operation, waits for completion with a timeout and registers the
// result and flags onto the output pins.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [7:0]      ui_in,
    input  logic [7:0]      uio_in,
    output logic [7:0]      uo_out,
    output logic [7:0]      uio_out,
    output logic [7:0]      uio_oe,
    output logic [OP_W-1:0] alu_op,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic            alu_start,
    input  logic [7:0]      alu_result,
    input  logic [3:0]      alu_flags,
    input  logic            alu_done
);

    localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    logic [OP_W-1:0]   op_q;
    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic [7:0]        result_q;
    logic [3:0]        flags_q;
    logic              err_q;
    logic              busy_q;
    logic              start_q;
    logic [CNT_W-1:0]  cnt_q;

    logic stb_rise;
    logic abort;
    logic ld;
    logic unused_uio;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stb (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (uio_in[UIO_STB]),
        .level_o (),
        .rise_o  (stb_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_abt (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (uio_in[UIO_ABT]),
        .level_o (abort),
        .rise_o  ()
    );

    // Strobe edges seen while disabled are discarded, not deferred.
    assign ld         = stb_rise & ena;
    assign unused_uio = ^uio_in[7:2];

    // Transaction FSM with registered start/busy and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LD_OP;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // Start is a single-cycle pulse even if ena drops during ISSUE.
            start_q <= 1'b0;
            if (ena) begin
                if (abort) begin
                    state_q <= ST_LD_OP;
                    busy_q  <= 1'b0;
                end else begin
                    case (state_q)
                        ST_LD_OP: if (ld) begin
                            op_q    <= ui_in[OP_W-1:0];
                            state_q <= ST_LD_A;
                        end
                        ST_LD_A: if (ld) begin
                            a_q     <= ui_in;
                            state_q <= ST_LD_B;
                        end
                        ST_LD_B: if (ld) begin
                            b_q     <= ui_in;
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= ST_ISSUE;
                        end
                        ST_ISSUE: begin
                            cnt_q   <= '0;
                            state_q <= ST_WAIT;
                        end
                        ST_WAIT: begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (alu_done) begin
                                result_q <= alu_result;
                                flags_q  <= alu_flags;
                                err_q    <= 1'b0;
                                busy_q   <= 1'b0;
                                state_q  <= ST_LD_OP;
                            end else if (cnt_q == CNT_LAST) begin
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_LD_OP;
                            end
                        end
                        default: begin
                            busy_q  <= 1'b0;
                            state_q <= ST_LD_OP;
                        end
                    endcase
                end
            end
        end
    end

    // Pack the status registers onto the uio output bits.
    always_comb begin
        // NOTE: default every bit first so no path through this block
        // leaves uio_out unassigned and infers a latch.
        uio_out                    = '0;
        uio_out[UIO_FLG_LSB +: 4]  = flags_q;
        uio_out[UIO_ERR]           = err_q;
        uio_out[UIO_BUSY]          = busy_q;
    end

    assign uo_out    = result_q;
    assign uio_oe    = UIO_OE;
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_start = start_q;

endmodule
